// File: rtl/alu_issue_unit.sv
// Issue front end for the shared ALU: decodes funct3/funct7 into ALU ctrl,
// registers operands, captures the ALU result/flags and resolves branches.
module alu_issue_unit #(
   parameter int REG_BITS = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2:0]          funct3,
   input  logic                funct7_5,
   input  logic                is_imm,
   input  logic                is_branch,
   input  logic [REG_BITS-1:0] rs1,
   input  logic [REG_BITS-1:0] rs2,
   input  logic [REG_BITS-1:0] imm,
   output logic [REG_BITS-1:0] alu_a,
   output logic [REG_BITS-1:0] alu_b,
   output logic [3:0]          alu_ctrl,
   input  logic [REG_BITS-1:0] alu_c,
   input  logic [3:0]          alu_onzc,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [REG_BITS-1:0] out_result,
   output logic [3:0]          out_flags,
   output logic                out_take,
   output logic                out_err
);

   localparam logic [3:0] C_ADD  = 4'b0000;
   localparam logic [3:0] C_SUB  = 4'b0001;
   localparam logic [3:0] C_AND  = 4'b0010;
   localparam logic [3:0] C_OR   = 4'b0011;
   localparam logic [3:0] C_XOR  = 4'b0100;
   localparam logic [3:0] C_SLT  = 4'b0101;
   localparam logic [3:0] C_SLL  = 4'b0110;
   localparam logic [3:0] C_SLTU = 4'b0111;
   localparam logic [3:0] C_SRL  = 4'b1000;
   localparam logic [3:0] C_SRA  = 4'b1001;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t     state, state_nxt;
   logic [3:0] dec_ctrl;
   logic       br_q;
   logic [2:0] f3_q;
   logic       take, err;
   logic       accept, capture;

   assign accept  = (state == IDLE) && in_valid;
   assign capture = (state == EXEC);

   always_comb begin
      dec_ctrl = C_ADD;
      if (is_branch) begin
         dec_ctrl = C_SUB;
      end else begin
         case (funct3)
            3'b000:  dec_ctrl = (funct7_5 && !is_imm) ? C_SUB : C_ADD;
            3'b001:  dec_ctrl = C_SLL;
            3'b010:  dec_ctrl = C_SLT;
            3'b011:  dec_ctrl = C_SLTU;
            3'b100:  dec_ctrl = C_XOR;
            3'b101:  dec_ctrl = funct7_5 ? C_SRA : C_SRL;
            3'b110:  dec_ctrl = C_OR;
            default: dec_ctrl = C_AND;
         endcase
      end
   end

   // Branch condition from the live ALU flags of the latched compare (A - B).
   always_comb begin
      take = 1'b0;
      err  = 1'b0;
      if (br_q) begin
         case (f3_q)
            3'b000:  take = alu_onzc[1];
            3'b001:  take = !alu_onzc[1];
            3'b100:  take = alu_onzc[2] ^ alu_onzc[3];
            3'b101:  take = !(alu_onzc[2] ^ alu_onzc[3]);
            3'b110:  take = !alu_onzc[0];
            3'b111:  take = alu_onzc[0];
            default: err  = 1'b1;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Operand registers only move on accept, so the ALU never sees raw inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a    <= '0;
         alu_b    <= '0;
         alu_ctrl <= C_ADD;
         br_q     <= 1'b0;
         f3_q     <= 3'b000;
      end else if (accept) begin
         alu_a    <= rs1;
         alu_b    <= (is_imm && !is_branch) ? imm : rs2;
         alu_ctrl <= dec_ctrl;
         br_q     <= is_branch;
         f3_q     <= funct3;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_result <= '0;
         out_flags  <= 4'b0000;
         out_take   <= 1'b0;
         out_err    <= 1'b0;
      end else if (capture) begin
         out_result <= alu_c;
         out_flags  <= alu_onzc;
         out_take   <= take;
         out_err    <= err;
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == RESP);

endmodule
